// File: rtl/cic_comb_decimator.sv
// rtl/cic_comb_decimator.sv - CIC decimator: rate reduction, comb cascade and output truncation
//
// Purpose:
//   This block sits after the integrator cascade of a CIC decimating filter.
//   It keeps one valid sample in every RATIO. It runs that sample through
//   STAGES pipelined comb stages, each computing y[n] = x[n] - x[n-DELAY].
//   It truncates the result to OUT_PRECISION bits and emits it with a
//   one-cycle strobe.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   x_valid  qualifies x; tie high when the integrators run every clock
//   x        last integrator output, two's complement, modulo arithmetic
//   y        decimated, filtered, truncated sample; holds between strobes
//   y_valid  one-cycle strobe marking a new y
module cic_comb_decimator #(
  parameter int PRECISION     = 12,
  parameter int OUT_PRECISION = 12,
  parameter int STAGES        = 3,
  parameter int DELAY         = 1,
  parameter int RATIO         = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_valid,
  input  logic [PRECISION-1:0]     x,
  output logic [OUT_PRECISION-1:0] y,
  output logic                     y_valid
);

  // A one-bit counter is kept for RATIO = 1. It simply stays at zero.
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]     cnt;
  logic [PRECISION-1:0] d0;
  // tok[k] marks that the sample feeding stage k+1 is fresh this cycle.
  // tok[0] follows d0, and tok[STAGES] follows the last comb register.
  logic [STAGES:0]      tok;
  logic [PRECISION-1:0] comb_q   [STAGES];
  logic [PRECISION-1:0] stage_in [STAGES];
  logic                 dec_pt;

  assign dec_pt = x_valid && (cnt == CNT_LAST);

  always_comb begin
    stage_in[0] = d0;
    for (int k = 1; k < STAGES; k++) begin
      stage_in[k] = comb_q[k-1];
    end
  end

  // Decimation counter, sample capture, token pipeline and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      d0      <= '0;
      tok     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      if (x_valid) begin
        cnt <= dec_pt ? '0 : cnt + 1'b1;
      end
      if (dec_pt) begin
        d0 <= x;
      end
      tok     <= {tok[STAGES-1:0], dec_pt};
      y_valid <= tok[STAGES];
      if (tok[STAGES]) begin
        y <= comb_q[STAGES-1][PRECISION-1 -: OUT_PRECISION];
      end
    end
  end

  // Comb stages. Each stage moves only when its token is present, so the
  // delay lines run at the decimated rate. The subtraction wraps modulo
  // 2^PRECISION on purpose. Integrator overflow cancels here only if it does.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic [PRECISION-1:0] line_q [DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        comb_q[k] <= '0;
        for (int j = 0; j < DELAY; j++) begin
          line_q[j] <= '0;
        end
      end else if (tok[k]) begin
        comb_q[k] <= stage_in[k] - line_q[DELAY-1];
        line_q[0] <= stage_in[k];
        for (int j = 1; j < DELAY; j++) begin
          line_q[j] <= line_q[j-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_comb_decimator.sv
// tb/tb_cic_comb_decimator.sv - scoreboard bench for cic_comb_decimator against a binomial comb model
module tb_cic_comb_decimator;

  localparam int P = 14;
  localparam int O = 12;
  localparam int S = 3;
  localparam int M = 2;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         x_valid;
  logic [P-1:0] x;
  logic [O-1:0] y;
  logic         y_valid;

  cic_comb_decimator #(
    .PRECISION(P), .OUT_PRECISION(O), .STAGES(S), .DELAY(M), .RATIO(R)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic [O-1:0] exp_v[$];
  int           exp_c[$];
  longint       hist[$];
  int           vcnt = 0;
  logic [O-1:0] last_y = '0;

  // The comb cascade is (1 - z^-M)^S over the decimated sequence.
  // The model expands it binomially, taking history before reset as zero.
  function automatic logic [O-1:0] ref_out();
    longint acc;
    longint b;
    int     n;
    int     idx;
    acc = 0;
    b   = 1;
    n   = hist.size() - 1;
    for (int i = 0; i <= S; i++) begin
      idx = n - i * M;
      if (idx >= 0) acc += ((i % 2) ? -b : b) * hist[idx];
      b = b * (S - i) / (i + 1);
    end
    acc = acc & ((longint'(1) << P) - 1);
    return O'(acc >> (P - O));
  endfunction

  task automatic step(input logic v, input logic [P-1:0] xv);
    logic dec;
    dec     = v && (vcnt == R - 1);
    x_valid = v;
    x       = xv;
    @(posedge clk);
    #1;
    if (v) vcnt = dec ? 0 : vcnt + 1;
    if (dec) begin
      hist.push_back(longint'(xv));
      exp_v.push_back(ref_out());
      exp_c.push_back(cyc + S + 1);
    end
  endtask

  task automatic reset_midflight();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== '0) begin
      errors++;
      $display("FAIL async_reset_y got=%0h want=0", y);
    end
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_y_valid got=%0b want=0", y_valid);
    end
    exp_v.delete();
    exp_c.delete();
    hist.delete();
    vcnt    = 0;
    last_y  = '0;
    x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per strobe and checks both value and arrival cycle.
  always @(negedge clk) begin
    logic [O-1:0] ev;
    int           ec;
    while (exp_c.size() > 0 && exp_c[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_strobe due_cycle=%0d now=%0d", exp_c[0], cyc);
      void'(exp_v.pop_front());
      void'(exp_c.pop_front());
    end
    if (y_valid) begin
      checks++;
      if (exp_v.size() == 0) begin
        errors++;
        $display("FAIL spurious_strobe cycle=%0d y=%0h", cyc, y);
      end else begin
        ev = exp_v.pop_front();
        ec = exp_c.pop_front();
        if (y !== ev) begin
          errors++;
          $display("FAIL y_value cycle=%0d got=%0h want=%0h", cyc, y, ev);
        end
        checks++;
        if (cyc != ec) begin
          errors++;
          $display("FAIL strobe_cycle got=%0d want=%0d", cyc, ec);
        end
        last_y = ev;
      end
    end else if (rst_n) begin
      checks++;
      if (y !== last_y) begin
        errors++;
        $display("FAIL y_hold cycle=%0d got=%0h want=%0h", cyc, y, last_y);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x       = '0;
    #1;
    checks++;
    if (y !== '0) begin
      errors++;
      $display("FAIL reset_y got=%0h want=0", y);
    end
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_y_valid got=%0b want=0", y_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp with x_valid held high.
    for (int i = 1; i <= 40; i++) step(1'b1, P'(i));
    // Gapped ramp: every other cycle invalid.
    for (int i = 0; i < 40; i++) step((i % 2) == 0, P'(41 + i / 2));
    // Values crossing the 2^P wrap point.
    for (int i = 0; i < 40; i++) step(1'b1, P'(16370 + i * 3));
    // Impulse landing on a decimation point.
    while (vcnt != R - 1) step(1'b1, '0);
    step(1'b1, P'(8191));
    repeat (30) step(1'b1, '0);
    // Random data with random gaps.
    repeat (300) step($urandom_range(0, 3) != 0, P'($urandom));

    // Reset while tokens are in flight, then resume from zero history.
    for (int r = 0; r < 2; r++) begin
      do step(1'b1, P'($urandom)); while (vcnt != 0);
      step(1'b1, P'($urandom));
      reset_midflight();
      for (int i = 1; i <= 24; i++) step(1'b1, P'(i * 5));
      repeat (100) step($urandom_range(0, 2) != 0, P'($urandom));
    end

    repeat (S + 4) step(1'b0, '0);
    checks++;
    if (exp_v.size() != 0) begin
      errors++;
      $display("FAIL pending_outputs got=%0d want=0", exp_v.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cic_comb_decimator.md
# cic_comb_decimator

Decimation and comb section of the Cascaded Integrator-Comb (CIC) decimating filter. It sits directly downstream of the integrator cascade. It takes the last integrator's full-rate output, keeps one sample in every RATIO, and passes that sample through STAGES pipelined comb stages, each computing y[n] = x[n] − x[n−DELAY]. It then truncates the result to the output width and emits it with a one-cycle valid strobe at the decimated rate.

## Interface
- PRECISION, 12: internal datapath width. Must match the integrator width, which is sized by the instantiator as Bin + STAGES·ceil(log2(RATIO·DELAY)).
- OUT_PRECISION, 12: output width. Must satisfy 1 ≤ OUT_PRECISION ≤ PRECISION.
- STAGES, 3: number of comb stages (N). Must be ≥ 1; must equal the integrator stage count.
- DELAY, 1: differential delay M. Must be ≥ 1.
- RATIO, 8: decimation ratio R. Must be ≥ 1.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- x_valid  input  1  input sample qualifier. Tie high when the integrators run every clock.
- x  input  PRECISION  last integrator stage output (two's-complement, modulo arithmetic).
- y  output  OUT_PRECISION  filtered, decimated, truncated sample.
- y_valid  output  1  one-cycle strobe marking a new y.

## Operation
- Decimation counter `cnt`, range 0..RATIO−1, reset 0.
  - Advances only on clocks where x_valid = 1.
- Decimation point: x_valid = 1 and cnt = RATIO−1.
  - x is captured into the decimated-sample register d0.
  - A token is launched into the valid pipeline.
  - cnt returns to 0.
  - With RATIO = 1, every valid sample is a decimation point.
- Non-decimated valid samples are discarded. Invalid cycles change nothing except the pipeline advance described below.
- Comb stage k (k = 1..STAGES):
  - Registers c_k = in_k − line_k[DELAY−1], where in_1 = d0 and in_k = c_(k−1).
  - line_k is a DELAY-deep shift register of past in_k values.
  - line_k shifts, and c_k updates, only when the token is present at stage k. Delay lines therefore operate at the decimated rate.
- The pipeline is fully streaming with no stall or backpressure. Each token advances one stage per clock regardless of x_valid.
- All subtraction is PRECISION bits, modulo 2^PRECISION.
  - Wrap-around is required, never saturated; CIC correctness depends on it.
- Output register: y = c_STAGES[PRECISION−1 : PRECISION−OUT_PRECISION]. This drops LSBs by truncation, with no rounding.
  - y holds its value between strobes.
- Reset (asynchronous, mid-operation included):
  - cnt, d0, every c_k, every line_k entry, the token pipeline, y and y_valid all go to 0 immediately.
  - In-flight samples are lost; no y_valid is produced for them.

## Timing
- Reset values: y = 0, y_valid = 0.
- Latency: a decimation point sampled at rising edge t produces y_valid = 1 during the cycle after edge t+STAGES+1, for exactly one clock.
- Output rate: one y_valid per RATIO accepted x_valid samples. Consecutive strobes are at least RATIO clocks apart.
- First output after reset release: produced by the RATIO-th valid sample. Delay lines start at zero, so the first DELAY outputs per stage reflect zero history.
- Simultaneous events are independent of each other:
  - A new decimation point may coincide with earlier tokens in any stage, including an output strobe.

## Test plan
- Ramp / DC:
  - Setup: STAGES=1, DELAY=1, RATIO=4, PRECISION=OUT_PRECISION=12; x_valid held high; x = 1,2,3,4,5,...
  - Required: y = 4, 4, 4, ...; y_valid every 4th clock; first strobe STAGES+1 = 2 cycles after the clock where x=4 is sampled.
- Wrap-around:
  - Setup: same configuration; decimated inputs 4090, 4094, 2, 6 (x wraps past 4095).
  - Required: y = 4090, 4, 4, 4, with no saturation.
- Impulse:
  - Setup: STAGES=3, DELAY=1, RATIO=1; x = 1 for one valid sample, then 0.
  - Required: y = 1, 4093, 3, 4095, 0, ... (that is, 1, −3, 3, −1); first strobe 4 cycles after the impulse is sampled.
- Gapped input:
  - Setup: RATIO=4; x_valid toggling 1,0,1,0,...
  - Required: y_valid once per 8 clocks; output values identical to the gap-free run.
- Truncation:
  - Setup: PRECISION=16, OUT_PRECISION=12, STAGES=1, RATIO=1; decimated inputs 0, 0x1234.
  - Required: y = 0x000 then 0x123.
- Reset mid-flight:
  - Stimulus: drop rst_n while tokens are in stages 1..STAGES.
  - Required: y and y_valid go to 0 without waiting for a clock; no stale strobe; after release, the first y_valid follows RATIO new valid samples plus the normal latency, with zeroed history.
